pc_branch_unit: RTL
===================

Name: pc_branch_unit

Overview:
- Consumes the 2-bit branch code produced by the instruction decoder and owns the program counter, the Z/V/N flag register and the halt state of the single-cycle 16-bit core.
- Each cycle it computes the next PC: sequential, PC-relative conditional branch, register-indirect, or halt.
- It supplies the current PC to instruction fetch and PC+2 to the register write-back path for the PCS instruction.

Parameters:
- PC_WIDTH, 16, width of PC and rs operand.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  when 1, hold PC, flags and FSM state; suppress all updates.
- branch  input  2  decoder branch code: 0 = PC+2, 1 = conditional (PC+2)+offset, 2 = rs, 3 = halt.
- cond  input  3  condition code, instruction bits [11:9].
- imm9  input  9  signed word offset, instruction bits [8:0].
- rs_data  input  PC_WIDTH  register-indirect target.
- flag_we  input  3  per-flag write enable {Z,V,N}; ADD/SUB assert 3'b111, XOR/SLL/SRA/ROR assert 3'b100, others 3'b000.
- alu_z, alu_v, alu_n  input  1 each  ALU flag results for the current instruction.
- pc  output  PC_WIDTH  current PC (registered).
- pc_plus2  output  PC_WIDTH  pc+2, combinational, mod 2^PC_WIDTH.
- taken  output  1  combinational; 1 when the next PC differs from pc_plus2 because of a branch.
- halted  output  1  registered; 1 once HLT has retired.
- flags  output  3  registered {Z,V,N}.

Behaviour:
- Reset (sync, rst=1 at posedge): pc=RESET_PC, flags=3'b000, FSM=RUN, halted=0. Reset overrides stall and applies in any state, including HALT.
- FSM states: RUN, HALT.
  - RUN: if stall=1, hold everything. Otherwise, at posedge, pc <= next_pc and flags update per flag_we. If branch==3, go to HALT; pc holds and flags still update per flag_we.
  - HALT: pc, flags and halted frozen; all inputs ignored except rst. Exit only via reset.
- halted=1 exactly when FSM=HALT (registered). It rises the cycle after the HLT posedge.
- Condition evaluation uses the registered flags. This is the pre-update value, so a same-cycle flag write does not affect the current branch.
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | (Z=0 & N=0)
  - 101 LTE: N=1 | Z=1
  - 110 OVFL: V=1
  - 111: always
- next_pc:
  - branch 0: pc_plus2.
  - branch 1: pc_plus2 + (sign_extend(imm9) << 1) when cond true, else pc_plus2.
  - branch 2: {rs_data[PC_WIDTH-1:1], 1'b0}. Bit 0 is forced to 0.
  - branch 3: pc.
- All address arithmetic is mod 2^PC_WIDTH, e.g. 0xFFFE+2 = 0x0000, and a negative offset past 0 wraps.
- taken:
  - 1 for branch==2 always.
  - 1 for branch==1 with cond true. This holds even when the offset is 0.
  - 0 otherwise, including halt, stall and HALT state.
- flags update only when stall=0 and FSM=RUN. Bits with flag_we=0 keep their value.
- Stall and HLT in the same cycle: stall wins and HALT is not entered until HLT is presented with stall=0.

Test Plan:
- Reset then 3 cycles of branch=0: pc goes 0x0000→0x0002→0x0004→0x0006; taken=0; flags=000.
- With Z=1 latched (flag_we=100, alu_z=1 in the prior cycle), pc=0x0010, branch=1, cond=001, imm9=9'h1FE (−2): taken=1 and next pc=0x000E. Repeat with cond=000: taken=0 and pc=0x0012.
- Same-cycle flag write: flags=000, branch=1, cond=001, flag_we=111, alu_z=1. The branch is not taken (old Z=0) and flags=100 afterwards.
- branch=2 with rs_data=0x1235: pc becomes 0x1234 and taken=1. With pc=0xFFFE and branch=0: pc becomes 0x0000.
- HLT at pc=0x0040: halted=1 next cycle. pc stays 0x0040 for 5 cycles of arbitrary branch/flag_we inputs. Asserting rst then gives pc=RESET_PC, halted=0, flags=000.
- stall=1 with branch=3 and flag_we=111: pc, flags and halted are unchanged. Deasserting stall with the same inputs enters HALT.

Source files
------------

// File: rtl/pc_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_branch_unit_if
// Brief    : Decoder/ALU-side bundle for the PC and branch unit.
// Revision : 1.0
// ============================================================================
interface pc_branch_unit_if #(
    parameter int PC_WIDTH = 16
);
    logic                stall;
    logic [1:0]          branch;
    logic [2:0]          cond;
    logic [8:0]          imm9;
    logic [PC_WIDTH-1:0] rs_data;
    logic [2:0]          flag_we;
    logic                alu_z;
    logic                alu_v;
    logic                alu_n;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus2;
    logic                taken;
    logic                halted;
    logic [2:0]          flags;

    modport master (
        output stall, branch, cond, imm9, rs_data, flag_we, alu_z, alu_v, alu_n,
        input  pc, pc_plus2, taken, halted, flags
    );

    modport slave (
        input  stall, branch, cond, imm9, rs_data, flag_we, alu_z, alu_v, alu_n,
        output pc, pc_plus2, taken, halted, flags
    );
endinterface
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_branch_unit
// Brief    : Program counter, Z/V/N flag register and halt state of the core.
// Revision : 1.0
// ============================================================================
module pc_branch_unit #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pc_branch_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [PC_WIDTH-1:0] c_two     = PC_WIDTH'(2);
    localparam logic [PC_WIDTH-1:0] c_lsb_clr = ~PC_WIDTH'(1);

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [2:0]          flags_q;
    logic [2:0]          flags_d;
    logic                halted_q;

    logic [PC_WIDTH-1:0] w_pc_plus2;
    logic [PC_WIDTH-1:0] w_offset;
    logic                w_cond_true;
    logic                w_active;
    logic                w_z;
    logic                w_v;
    logic                w_n;

    assign w_z        = flags_q[2];
    assign w_v        = flags_q[1];
    assign w_n        = flags_q[0];
    assign w_active   = (state_q == ST_RUN) && !bus.stall;
    assign w_pc_plus2 = pc_q + c_two;
    // Word offset: sign-extend imm9 and scale by 2 in one concatenation.
    assign w_offset   = {{(PC_WIDTH-10){bus.imm9[8]}}, bus.imm9, 1'b0};

    always_comb begin
        w_cond_true = 1'b0;
        case (bus.cond)
            3'b000:  w_cond_true = !w_z;
            3'b001:  w_cond_true = w_z;
            3'b010:  w_cond_true = !w_z && !w_n;
            3'b011:  w_cond_true = w_n;
            3'b100:  w_cond_true = w_z || (!w_z && !w_n);
            3'b101:  w_cond_true = w_n || w_z;
            3'b110:  w_cond_true = w_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    always_comb begin
        pc_d = w_pc_plus2;
        case (bus.branch)
            2'd0:    pc_d = w_pc_plus2;
            2'd1:    pc_d = w_cond_true ? (w_pc_plus2 + w_offset) : w_pc_plus2;
            2'd2:    pc_d = bus.rs_data & c_lsb_clr;
            default: pc_d = pc_q;
        endcase
    end

    assign flags_d = (flags_q & ~bus.flag_we)
                   | ({bus.alu_z, bus.alu_v, bus.alu_n} & bus.flag_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            flags_q  <= 3'b000;
            halted_q <= 1'b0;
        end else if (w_active) begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
            if (bus.branch == 2'd3) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus2 = w_pc_plus2;
    assign bus.flags    = flags_q;
    assign bus.halted   = halted_q;
    // Only real redirects count; halt and suppressed cycles never report taken.
    assign bus.taken    = w_active
                       && ((bus.branch == 2'd2) || ((bus.branch == 2'd1) && w_cond_true));

endmodule
`default_nettype wire
